// File: rtl/priority_encoder_8to3_if.sv
// Request/result bundle for the 8-to-3 priority encoder.
// The master drives the request lines; the slave (encoder) returns the code and valid flag.
interface priority_encoder_8to3_if;
  logic p0;
  logic p1;
  logic p2;
  logic p3;
  logic p4;
  logic p5;
  logic p6;
  logic p7;
  logic z1;
  logic z2;
  logic z4;
  logic v;

  modport master (
    output p0, p1, p2, p3, p4, p5, p6, p7,
    input  z1, z2, z4, v
  );

  modport slave (
    input  p0, p1, p2, p3, p4, p5, p6, p7,
    output z1, z2, z4, v
  );
endinterface

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder: the index of the highest asserted request (p7 wins)
// appears one clock after sampling, with v flagging that any request was present.
module priority_encoder_8to3 (
  input logic                  clk,
  input logic                  rst_n,
  priority_encoder_8to3_if.slave bus
);

  logic [7:0] req_s;
  logic [2:0] code_d;
  logic [2:0] code_q;
  logic       v_d;
  logic       v_q;

  assign req_s = {bus.p7, bus.p6, bus.p5, bus.p4, bus.p3, bus.p2, bus.p1, bus.p0};

  // Priority decode; an empty request vector yields code 000 with v low.
  always_comb begin
    code_d = 3'b000;
    v_d    = 1'b0;
    casez (req_s)
      8'b1???_????: begin code_d = 3'd7; v_d = 1'b1; end
      8'b01??_????: begin code_d = 3'd6; v_d = 1'b1; end
      8'b001?_????: begin code_d = 3'd5; v_d = 1'b1; end
      8'b0001_????: begin code_d = 3'd4; v_d = 1'b1; end
      8'b0000_1???: begin code_d = 3'd3; v_d = 1'b1; end
      8'b0000_01??: begin code_d = 3'd2; v_d = 1'b1; end
      8'b0000_001?: begin code_d = 3'd1; v_d = 1'b1; end
      8'b0000_0001: begin code_d = 3'd0; v_d = 1'b1; end
      default:      begin code_d = 3'b000; v_d = 1'b0; end
    endcase
  end

  // Output registers, cleared asynchronously so reset takes effect without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= 3'b000;
      v_q    <= 1'b0;
    end else begin
      code_q <= code_d;
      v_q    <= v_d;
    end
  end

  assign bus.z1 = code_q[0];
  assign bus.z2 = code_q[1];
  assign bus.z4 = code_q[2];
  assign bus.v  = v_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench for priority_encoder_8to3: vector table, multi-cycle corner cases,
// and randomized patterns against a floor-log2 reference model.
module tb_priority_encoder_8to3;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  priority_encoder_8to3_if bus ();

  priority_encoder_8to3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    logic [2:0] z;
    logic       v;
  } vec_t;

  vec_t tbl [14];

  task automatic set_p(input logic [7:0] p);
    {bus.p7, bus.p6, bus.p5, bus.p4, bus.p3, bus.p2, bus.p1, bus.p0} = p;
  endtask

  task automatic check(input string name, input logic [2:0] exp_z, input logic exp_v);
    logic [2:0] got_z;
    logic       got_v;
    got_z = {bus.z4, bus.z2, bus.z1};
    got_v = bus.v;
    n_vec++;
    if (got_z !== exp_z || got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got z=%b v=%b, expected z=%b v=%b", name, got_z, got_v, exp_z, exp_v);
    end
  endtask

  // Reference: highest set bit index via repeated halving (floor log2), valid = any bit set.
  function automatic logic [3:0] ref_enc(input logic [7:0] p);
    int val;
    int n;
    val = int'(p);
    n   = 0;
    while (val > 1) begin
      val = val / 2;
      n++;
    end
    return {(p != 8'd0), 3'(n)};
  endfunction

  task automatic step(input logic [7:0] p, input string name, input logic [2:0] exp_z, input logic exp_v);
    set_p(p);
    @(posedge clk);
    #1;
    check(name, exp_z, exp_v);
  endtask

  initial begin
    logic [3:0] r;
    logic [7:0] rp;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_p(8'h00);

    for (int i = 0; i < 8; i++) begin
      tbl[i].p = 8'd1 << i;
      tbl[i].z = 3'(i);
      tbl[i].v = 1'b1;
    end
    tbl[8]  = '{p: 8'b0000_0000, z: 3'b000, v: 1'b0};
    tbl[9]  = '{p: 8'b0100_0001, z: 3'b110, v: 1'b1};
    tbl[10] = '{p: 8'b1111_1111, z: 3'b111, v: 1'b1};
    tbl[11] = '{p: 8'b0000_0011, z: 3'b001, v: 1'b1};
    tbl[12] = '{p: 8'b0001_1010, z: 3'b100, v: 1'b1};
    tbl[13] = '{p: 8'b0000_0001, z: 3'b000, v: 1'b1};

    // Reset held with random requests toggling
    #1;
    check("reset_initial", 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      set_p(8'($urandom_range(1, 255)));
      @(posedge clk);
      #1;
      check("reset_hold", 3'b000, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(8'b0010_0000, "first_after_release", 3'b101, 1'b1);

    // Table: one-hot sweep, empty, priority and back-to-back patterns
    foreach (tbl[i]) begin
      step(tbl[i].p, $sformatf("table[%0d]", i), tbl[i].z, tbl[i].v);
    end

    // Latency: mid-cycle input change must not reach outputs before the edge
    step(8'b1000_0000, "latency_setup", 3'b111, 1'b1);
    #2;
    set_p(8'b0000_0100);
    #2;
    check("latency_hold", 3'b111, 1'b1);
    @(posedge clk);
    #1;
    check("latency_update", 3'b010, 1'b1);

    // Reset mid-run: asynchronous clear, resume on first edge after release
    step(8'b1000_0000, "midreset_setup", 3'b111, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_async_clear", 3'b000, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    check("midreset_no_edge_yet", 3'b000, 1'b0);
    @(posedge clk);
    #1;
    check("midreset_resume", 3'b111, 1'b1);

    // Random patterns against the reference model
    for (int i = 0; i < 1000; i++) begin
      rp = 8'($urandom_range(0, 255));
      r  = ref_enc(rp);
      step(rp, $sformatf("random[%0d] p=%b", i, rp), r[2:0], r[3]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
